// File: rtl/keypad_scan_3x3.sv
// keypad_scan_3x3: 3x3 matrix keypad scanner with column synchroniser,
// full-scan snapshot debounce and one-hot key output.
// Optional build macro KEY_REPEAT_EN adds key_valid auto-repeat while a
// single accepted key stays held.
module keypad_scan_3x3 #(
  parameter int SCAN_DIV     = 4,
  parameter int DEB_SCANS    = 3,
  parameter int REPEAT_SCANS = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] row_out,
  input  logic [2:0] col_in,
  output logic [8:0] data_out,
  output logic       key_valid,
  output logic       multi_err
);

  localparam int             CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [3:0]     DEB      = 4'(DEB_SCANS);

  // Elaboration-time guard on parameter ranges
  if (SCAN_DIV < 4 || DEB_SCANS < 2 || DEB_SCANS > 15 || REPEAT_SCANS < 1) begin : g_param_chk
    $error("keypad_scan_3x3: illegal parameter value");
  end

  typedef enum logic [1:0] {ROW0 = 2'd0, ROW1 = 2'd1, ROW2 = 2'd2} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      row_q;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      cols;
  logic [8:0]      snap_q;
  logic            done_q;

  logic [8:0]      prev_q, prev_d;
  logic [8:0]      data_q, data_d;
  logic [3:0]      stab_q, stab_d;
  logic            kv_q, kv_d;
  logic            merr_q, merr_d;

`ifdef KEY_REPEAT_EN
  localparam int            RW       = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS - 1);
  logic [RW-1:0]   rep_q, rep_d;
`endif

  function automatic logic [3:0] popcnt(input logic [8:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 9; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Two-flop synchroniser on the asynchronous, pulled-up column lines
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= col_in;
      sync2_q <= sync1_q;
    end
  end

  // Columns are active-low at the pins; flip so pressed reads as 1
  assign cols = ~sync2_q;

  // Row scan FSM: each row held SCAN_DIV clocks, columns captured on its last clock
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ROW0;
      cnt_q   <= '0;
      row_q   <= 3'b110;
      snap_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        case (state_q)
          ROW0: begin
            snap_q[2:0] <= cols;
            state_q     <= ROW1;
            row_q       <= 3'b101;
          end
          ROW1: begin
            snap_q[5:3] <= cols;
            state_q     <= ROW2;
            row_q       <= 3'b011;
          end
          default: begin
            snap_q[8:6] <= cols;
            state_q     <= ROW0;
            row_q       <= 3'b110;
            done_q      <= 1'b1;  // full snapshot now complete in snap_q
          end
        endcase
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Debounce and acceptance, evaluated the clock after each completed snapshot
  always_comb begin
    prev_d = prev_q;
    stab_d = stab_q;
    data_d = data_q;
    merr_d = merr_q;
    kv_d   = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d  = rep_q;
`endif
    if (done_q) begin
      if (snap_q == prev_q) begin
        if (stab_q != DEB) stab_d = stab_q + 4'd1;
        // Accept only on the transition into DEB, never while saturated
        if (stab_q == DEB - 4'd1) begin
          if (popcnt(snap_q) == 4'd0) begin
            data_d = '0;
            merr_d = 1'b0;
          end else if (popcnt(snap_q) == 4'd1) begin
            kv_d   = (snap_q != data_q);
            data_d = snap_q;
            merr_d = 1'b0;
          end else begin
            data_d = '0;
            merr_d = 1'b1;
          end
`ifdef KEY_REPEAT_EN
          rep_d = '0;
        end else if (stab_q == DEB && data_q != '0) begin
          // Held single key: re-pulse every REPEAT_SCANS scans after acceptance
          if (rep_q == REP_LAST) begin
            kv_d  = 1'b1;
            rep_d = '0;
          end else begin
            rep_d = rep_q + RW'(1);
          end
`endif
        end
      end else begin
        stab_d = 4'd1;
        prev_d = snap_q;
`ifdef KEY_REPEAT_EN
        rep_d  = '0;
`endif
      end
    end
  end

  // Debounce state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      stab_q <= '0;
      data_q <= '0;
      kv_q   <= 1'b0;
      merr_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_q  <= '0;
`endif
    end else begin
      prev_q <= prev_d;
      stab_q <= stab_d;
      data_q <= data_d;
      kv_q   <= kv_d;
      merr_q <= merr_d;
`ifdef KEY_REPEAT_EN
      rep_q  <= rep_d;
`endif
    end
  end

  assign row_out   = row_q;
  assign data_out  = data_q;
  assign key_valid = kv_q;
  assign multi_err = merr_q;

endmodule

// File: doc/keypad_scan_3x3.md
Name: keypad_scan_3x3

Overview:
- Upstream stage of the one-hot-to-8421 BCD encoder. Scans a 3x3 matrix keypad (digits 1-9), synchronises and debounces the column lines, and presents a stable 9-bit one-hot key vector.
- data_out feeds the encoder's 9-bit data_in directly. All-zero means no key, or digit 0 at the encoder.

Parameters:
- SCAN_DIV, 4: clocks each row is driven per scan step. Legal range is 4 or more.
- DEB_SCANS, 3: consecutive identical full-scan snapshots required before a value is accepted. Legal range is 2 to 15.
- REPEAT_SCANS, 16: auto-repeat interval in full scans. Used only with KEY_REPEAT_EN.

Ports:
- clk  in  1  system clock; everything is synchronous to its rising edge.
- rst  in  1  synchronous, active-high reset.
- row_out  out  3  row drive, active-low, one-cold. Bit r drives keypad row r.
- col_in  in  3  column sense, active-low, asynchronous. Externally pulled up.
- data_out  out  9  debounced one-hot key. Bit k = row*3+col = digit k+1.
- key_valid  out  1  single-cycle pulse when data_out takes a new nonzero value.
- multi_err  out  1  level. High while the accepted snapshot has 2 or more keys pressed.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - row_out=3'b110.
  - Scan state ROW0 and row-period counter 0.
  - Synchroniser flops to 3'b111.
  - Snapshot and previous snapshot to 0; stable counter 0.
  - data_out=0, key_valid=0, multi_err=0.
- Reset mid-scan or mid-debounce discards all partial state. No key_valid is produced by reset.
- Input synchroniser: col_in passes through 2 flops, then is inverted, so pressed=1.
- Scan FSM:
  - States ROW0, ROW1, ROW2, with row_out = 110, 101, 011 respectively.
  - Each state lasts SCAN_DIV clocks, then moves ROW0 -> ROW1 -> ROW2 -> ROW0.
  - On the last clock of each state, synchronised columns c[2:0] are captured into snapshot bits [row*3+2 : row*3].
  - One full scan is 3*SCAN_DIV clocks. A full snapshot is complete at the last clock of ROW2.
- Debounce, evaluated once per completed snapshot S:
  - If S equals the previous snapshot, the stable counter increments, saturating at DEB_SCANS.
  - Otherwise the stable counter is set to 1 and the previous snapshot takes S.
- Acceptance happens on the snapshot where the counter becomes exactly DEB_SCANS. No re-acceptance until the counter restarts. Results by popcount(S):
  - 0: data_out=0, multi_err=0.
  - 1: data_out=S, multi_err=0. key_valid pulses if S differs from the old data_out.
  - 2 or more: data_out=0, multi_err=1. No key_valid.
- Registered outputs update on the clock after snapshot completion. key_valid is high for exactly that one cycle.
- Latency: first press-inclusive snapshot + (DEB_SCANS-1) full scans + 1 clk, plus up to 2 clk of synchroniser delay.
- Key change without release (A to B): once B is stable for DEB_SCANS snapshots, data_out=B and key_valid pulses.
- A bounce shorter than one scan step may not be sampled at all; this is intended.
- Release: data_out returns to 0 after DEB_SCANS stable zero snapshots. No pulse.
- Counter widths: the row counter is wide enough for SCAN_DIV-1. The stable counter is 4 bits.

Optional Feature:
- Macro KEY_REPEAT_EN.
- Defined: while an accepted single key stays stable (snapshot unchanged), a repeat counter counts full scans after acceptance.
  - key_valid re-pulses every REPEAT_SCANS full scans. data_out is unchanged.
  - Any snapshot change, or rst, clears the repeat counter.
- Undefined: exactly one key_valid per accepted press. The repeat counter logic is absent.

Test Plan:
- Reset: rst=1 for 2 clk, then rst=0 -> row_out=110, data_out=0, key_valid=0, multi_err=0. row_out is 101 after 4 clk and 011 after 8 clk.
- Single press, digit 5 (row1,col1, col_in[1] low while row_out=101), held 10 scans -> data_out=9'b000010000, key_valid exactly once. With the encoder attached, its output is 4'b0101.
- Bounce: digit 9 toggled on alternate scans for 6 scans, then held -> no output change during bouncing. data_out=9'b100000000 exactly 2 scans after the first of 3 consecutive steady snapshots, 1 pulse.
- Multi-key: digits 1 and 3 held together -> data_out=0, multi_err=1, no pulse. Release of 3 -> data_out=9'b000000001, multi_err=0, 1 pulse.
- Release and reset mid-debounce: digit 2 accepted, then released -> data_out=0 after 3 zero snapshots. Press 4, then rst asserted after 1 stable snapshot -> all outputs 0. The press continues: pulse after 3 fresh snapshots.
- KEY_REPEAT_EN defined, REPEAT_SCANS=4, digit 7 held 20 scans -> pulses at acceptance and every 4 scans after (5 total within 3+16 scans). Without the macro -> 1 pulse.
